exu_operand_stage: RTL and testbench

Decode-to-execute pipeline stage of the NPC core, directly upstream of the ALU. Accepts decoded instructions with register-file operands, selects the two ALU operands (A, B) and the 4-bit ALU control, and holds them in a two-entry skid buffer with valid/ready handshakes on both sides. It owns the only registered boundary between decode and execute. Optionally, it forwards the writeback result onto operands at capture.

---
 rtl/exu_operand_if.sv | 51 +++++
 rtl/exu_operand_stage.sv | 140 ++++++++++++++
 tb/tb_exu_operand_stage.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/exu_operand_if.sv
// exu_operand_if: decode-side input bundle, ALU-side output bundle, flush and
// writeback bus of the decode-to-execute operand stage.
//   slave  : view used by exu_operand_stage
//   master : view used by the surrounding pipeline (or a testbench)
interface exu_operand_if;
    // upstream (decode) side
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_rs1_data;
    logic [31:0] in_rs2_data;
    logic [31:0] in_imm;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [4:0]  in_rd;
    logic        in_rd_wen;
    logic [1:0]  in_asel;
    logic [1:0]  in_bsel;
    logic [3:0]  in_alu_ctr;
    logic        flush;
    // downstream (ALU) side
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_a;
    logic [31:0] out_b;
    logic [3:0]  out_ctr;
    logic [31:0] out_pc;
    logic [31:0] out_store_data;
    logic [4:0]  out_rd;
    logic        out_rd_wen;
    // writeback bus
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    modport slave (
        input  in_valid, in_pc, in_rs1_data, in_rs2_data, in_imm,
        input  in_rs1, in_rs2, in_rd, in_rd_wen, in_asel, in_bsel, in_alu_ctr,
        input  flush, out_ready, wb_valid, wb_rd, wb_data,
        output in_ready, out_valid, out_a, out_b, out_ctr, out_pc,
        output out_store_data, out_rd, out_rd_wen
    );

    modport master (
        output in_valid, in_pc, in_rs1_data, in_rs2_data, in_imm,
        output in_rs1, in_rs2, in_rd, in_rd_wen, in_asel, in_bsel, in_alu_ctr,
        output flush, out_ready, wb_valid, wb_rd, wb_data,
        input  in_ready, out_valid, out_a, out_b, out_ctr, out_pc,
        input  out_store_data, out_rd, out_rd_wen
    );
endinterface

// File: rtl/exu_operand_stage.sv
// exu_operand_stage: decode-to-execute register boundary of the NPC core.
// Selects ALU operands A/B from the decoded fields, then holds them in a
// two-entry skid buffer (main drives the outputs, skid absorbs one entry of
// backpressure). in_ready depends only on registered state and rst.
// Optional feature macro EXU_FWD_EN: forward the writeback bus onto the rs1/rs2
// data at capture time; when undefined the wb_* signals are ignored.
module exu_operand_stage (
    input  logic          clk,
    input  logic          rst,
    exu_operand_if.slave  ops_if
);

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  ctr;
        logic [31:0] pc;
        logic [31:0] store_data;
        logic [4:0]  rd;
        logic        rd_wen;
    } entry_t;

    entry_t      main_q, main_d;
    entry_t      skid_q, skid_d;
    logic        main_valid_q, main_valid_d;
    logic        skid_valid_q, skid_valid_d;
    entry_t      in_entry;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic        in_ready_s;
    logic        in_fire;
    logic        out_fire;

    // Register-file data for one source, optionally replaced by the writeback
    // result when the writeback targets the same non-zero register.
    function automatic logic [31:0] src_operand(
        input logic [4:0]  idx,
        input logic [31:0] rf_data,
        input logic        wb_valid,
        input logic [4:0]  wb_rd,
        input logic [31:0] wb_data
    );
`ifdef EXU_FWD_EN
        if (wb_valid && (wb_rd != 5'd0) && (wb_rd == idx)) begin
            return wb_data;
        end else begin
            return rf_data;
        end
`else
        logic unused_s;
        unused_s = wb_valid ^ (^wb_rd) ^ (^wb_data) ^ (^idx);
        return rf_data;
`endif
    endfunction

    assign in_ready_s = !skid_valid_q && !rst;
    assign in_fire    = ops_if.in_valid && in_ready_s && !ops_if.flush;
    assign out_fire   = main_valid_q && ops_if.out_ready;

    assign rs1_val = src_operand(ops_if.in_rs1, ops_if.in_rs1_data,
                                 ops_if.wb_valid, ops_if.wb_rd, ops_if.wb_data);
    assign rs2_val = src_operand(ops_if.in_rs2, ops_if.in_rs2_data,
                                 ops_if.wb_valid, ops_if.wb_rd, ops_if.wb_data);

    // Operand selection for the incoming entry; reserved selects give zero.
    always_comb begin
        in_entry            = '0;
        in_entry.ctr        = ops_if.in_alu_ctr;
        in_entry.pc         = ops_if.in_pc;
        in_entry.store_data = rs2_val;
        in_entry.rd         = ops_if.in_rd;
        in_entry.rd_wen     = ops_if.in_rd_wen;
        case (ops_if.in_asel)
            2'b00:   in_entry.a = rs1_val;
            2'b01:   in_entry.a = ops_if.in_pc;
            default: in_entry.a = 32'd0;
        endcase
        case (ops_if.in_bsel)
            2'b00:   in_entry.b = rs2_val;
            2'b01:   in_entry.b = ops_if.in_imm;
            2'b10:   in_entry.b = 32'd4;
            default: in_entry.b = 32'd0;
        endcase
    end

    // Skid-buffer next state: main refills from skid first, then from input.
    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        if (ops_if.flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q || out_fire) begin
            if (skid_valid_q) begin
                // in_ready is low while skid is valid, so no input competes here
                main_d       = skid_q;
                main_valid_d = 1'b1;
                skid_valid_d = 1'b0;
            end else if (in_fire) begin
                main_d       = in_entry;
                main_valid_d = 1'b1;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (in_fire) begin
            skid_d       = in_entry;
            skid_valid_d = 1'b1;
        end else begin
            skid_valid_d = skid_valid_q;
        end
    end

    // State registers with synchronous reset clearing valids and data.
    always_ff @(posedge clk) begin
        if (rst) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign ops_if.in_ready       = in_ready_s;
    assign ops_if.out_valid      = main_valid_q;
    assign ops_if.out_a          = main_q.a;
    assign ops_if.out_b          = main_q.b;
    assign ops_if.out_ctr        = main_q.ctr;
    assign ops_if.out_pc         = main_q.pc;
    assign ops_if.out_store_data = main_q.store_data;
    assign ops_if.out_rd         = main_q.rd;
    assign ops_if.out_rd_wen     = main_q.rd_wen;

endmodule

// File: tb/tb_exu_operand_stage.sv
// tb_exu_operand_stage: directed literal checks plus randomized traffic
// compared every cycle against a queue-based model of the stage.
module tb_exu_operand_stage;

    logic clk;
    logic rst;
    int   n_pass;
    int   n_total;
    bit   done;

    exu_operand_if bus ();

    exu_operand_stage dut (
        .clk    (clk),
        .rst    (rst),
        .ops_if (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected contents of the stage, oldest first (capacity 2).
    logic [137:0] exp_q[$];

    task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // What the stage must capture for the inputs currently presented.
    function automatic logic [137:0] model_entry();
        logic [31:0] r1, r2, a, b;
        r1 = bus.in_rs1_data;
        r2 = bus.in_rs2_data;
`ifdef EXU_FWD_EN
        if (bus.wb_valid && bus.wb_rd != 5'd0 && bus.wb_rd == bus.in_rs1) r1 = bus.wb_data;
        if (bus.wb_valid && bus.wb_rd != 5'd0 && bus.wb_rd == bus.in_rs2) r2 = bus.wb_data;
`endif
        a = (bus.in_asel == 2'd0) ? r1 : (bus.in_asel == 2'd1) ? bus.in_pc : 32'd0;
        b = (bus.in_bsel == 2'd0) ? r2 : (bus.in_bsel == 2'd1) ? bus.in_imm :
            (bus.in_bsel == 2'd2) ? 32'd4 : 32'd0;
        return {a, b, bus.in_alu_ctr, bus.in_pc, r2, bus.in_rd, bus.in_rd_wen};
    endfunction

    // Model update on each rising edge from the stable inputs.
    always @(posedge clk) begin
        bit rdy, ifire, ofire;
        if (rst) begin
            exp_q.delete();
        end else begin
            rdy   = exp_q.size() < 2;
            ofire = (exp_q.size() > 0) && bus.out_ready;
            ifire = bus.in_valid && rdy && !bus.flush;
            if (bus.flush) begin
                exp_q.delete();
            end else begin
                if (ofire) void'(exp_q.pop_front());
                if (ifire) exp_q.push_back(model_entry());
            end
        end
    end

    // Compare DUT against the model on every falling edge.
    always @(negedge clk) begin
        if (!done) begin
            chk("in_ready", {159'd0, bus.in_ready}, {159'd0, (!rst && exp_q.size() < 2)});
            chk("out_valid", {159'd0, bus.out_valid}, {159'd0, (exp_q.size() > 0)});
            if (exp_q.size() > 0)
                chk("out_entry", {22'd0, bus.out_a, bus.out_b, bus.out_ctr, bus.out_pc,
                                  bus.out_store_data, bus.out_rd, bus.out_rd_wen},
                    {22'd0, exp_q[0]});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.in_valid = 1'b0; bus.in_pc = 32'd0; bus.in_rs1_data = 32'd0;
        bus.in_rs2_data = 32'd0; bus.in_imm = 32'd0; bus.in_rs1 = 5'd0;
        bus.in_rs2 = 5'd0; bus.in_rd = 5'd0; bus.in_rd_wen = 1'b0;
        bus.in_asel = 2'd0; bus.in_bsel = 2'd0; bus.in_alu_ctr = 4'd0;
        bus.flush = 1'b0; bus.out_ready = 1'b1;
        bus.wb_valid = 1'b0; bus.wb_rd = 5'd0; bus.wb_data = 32'd0;
    endtask

    task automatic put(input logic [31:0] rs1d, input logic [1:0] as, input logic [1:0] bs,
                       input logic [31:0] imm);
        bus.in_valid = 1'b1; bus.in_rs1_data = rs1d; bus.in_asel = as;
        bus.in_bsel = bs; bus.in_imm = imm;
    endtask

    task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
        chk(nm, {128'd0, act}, {128'd0, exp});
    endtask

    initial begin
        logic [31:0] fwd_exp;
        n_pass = 0; n_total = 0; done = 1'b0;
        rst = 1'b1;
        drive_idle();
        // reset held two cycles
        step(); step();
        lit("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        lit("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        lit("rst_out_a", bus.out_a, 32'd0);
        lit("rst_out_b", bus.out_b, 32'd0);
        rst = 1'b0;
        #1;
        lit("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

        // streaming: 8 back-to-back entries
        for (int i = 0; i < 8; i++) begin
            put(i, 2'd0, 2'd1, 32'h10);
            step();
            lit("stream_valid", {31'd0, bus.out_valid}, 32'd1);
            lit("stream_a", bus.out_a, i);
            lit("stream_b", bus.out_b, 32'h10);
        end
        bus.in_valid = 1'b0;
        step();

        // backpressure: 4 stalled cycles
        bus.out_ready = 1'b0;
        put(32'd100, 2'd0, 2'd1, 32'h10); step();
        lit("bp_ready_1", {31'd0, bus.in_ready}, 32'd1);
        put(32'd101, 2'd0, 2'd1, 32'h10); step();
        lit("bp_ready_2", {31'd0, bus.in_ready}, 32'd0);
        put(32'd102, 2'd0, 2'd1, 32'h10); step(); step();
        lit("bp_hold_a", bus.out_a, 32'd100);
        bus.out_ready = 1'b1; step();
        lit("bp_rel_a1", bus.out_a, 32'd101);
        step();
        lit("bp_rel_a2", bus.out_a, 32'd102);
        bus.in_valid = 1'b0; step();
        lit("bp_drained", {31'd0, bus.out_valid}, 32'd0);

        // selects
        bus.in_pc = 32'h8000_0004; bus.in_alu_ctr = 4'b1010;
        put(32'h1234, 2'd1, 2'd2, 32'h55); step();
        lit("sel_a_pc", bus.out_a, 32'h8000_0004);
        lit("sel_b_4", bus.out_b, 32'd4);
        lit("sel_ctr", {28'd0, bus.out_ctr}, 32'hA);
        put(32'h1234, 2'd3, 2'd3, 32'h55); step();
        lit("sel_a_res", bus.out_a, 32'd0);
        lit("sel_b_res", bus.out_b, 32'd0);
        bus.in_valid = 1'b0; step();

        // flush with both entries held
        bus.out_ready = 1'b0;
        put(32'd1, 2'd0, 2'd1, 32'h0); step();
        put(32'd2, 2'd0, 2'd1, 32'h0); step();
        put(32'h77, 2'd0, 2'd1, 32'h0); bus.flush = 1'b1; step();
        lit("flush_valid", {31'd0, bus.out_valid}, 32'd0);
        lit("flush_ready", {31'd0, bus.in_ready}, 32'd1);
        bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1; step();
        lit("flush_gone", {31'd0, bus.out_valid}, 32'd0);

        // forwarding
`ifdef EXU_FWD_EN
        fwd_exp = 32'hDEAD;
`else
        fwd_exp = 32'd0;
`endif
        bus.in_rs1 = 5'd5; bus.wb_valid = 1'b1; bus.wb_rd = 5'd5; bus.wb_data = 32'hDEAD;
        put(32'd0, 2'd0, 2'd1, 32'h0); step();
        lit("fwd_a", bus.out_a, fwd_exp);
        bus.in_rs1 = 5'd0; bus.wb_rd = 5'd0; step();
        lit("fwd_r0_a", bus.out_a, 32'd0);
        drive_idle(); step();

        // randomized traffic checked by the model
        for (int i = 0; i < 1500; i++) begin
            rst              = (i >= 700 && i < 702);
            bus.in_valid     = ($urandom_range(0, 3) != 0);
            bus.in_pc        = $urandom;
            bus.in_rs1_data  = $urandom;
            bus.in_rs2_data  = $urandom;
            bus.in_imm       = $urandom;
            bus.in_rs1       = 5'($urandom_range(0, 7));
            bus.in_rs2       = 5'($urandom_range(0, 7));
            bus.in_rd        = 5'($urandom_range(0, 31));
            bus.in_rd_wen    = 1'($urandom_range(0, 1));
            bus.in_asel      = 2'($urandom_range(0, 3));
            bus.in_bsel      = 2'($urandom_range(0, 3));
            bus.in_alu_ctr   = 4'($urandom_range(0, 15));
            bus.flush        = ($urandom_range(0, 31) == 0);
            bus.out_ready    = ($urandom_range(0, 3) != 0);
            bus.wb_valid     = 1'($urandom_range(0, 1));
            bus.wb_rd        = 5'($urandom_range(0, 7));
            bus.wb_data      = $urandom;
            step();
        end
        rst = 1'b0;
        drive_idle();
        step(); step();
        @(negedge clk);
        done = 1'b1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
